// File: rtl/rv32i_types.sv
// Shared RV32I types for the branch comparator: funct3 encodings, FSM states
// and the small decode helpers used when a compare resolves.
package rv32i_types;

  // All eight funct3 codes are named so reserved encodings can travel on the bus.
  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_RSV2 = 3'b010,
    BR_RSV3 = 3'b011,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } branch_funct3_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } cmp_iter_state_t;

  function automatic logic is_signed_br(branch_funct3_t op);
    return (op == BR_BLT) || (op == BR_BGE);
  endfunction

  // Returns {br_en, bad_op} from the final equal / less-than flags.
  function automatic logic [1:0] br_resolve(branch_funct3_t op, logic eq, logic lt);
    logic [1:0] r;
    r = 2'b00;
    case (op)
      BR_BEQ:           r = {eq, 1'b0};
      BR_BNE:           r = {!eq, 1'b0};
      BR_BLT, BR_BLTU:  r = {lt, 1'b0};
      BR_BGE, BR_BGEU:  r = {!lt, 1'b0};
      default:          r = 2'b01;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cmp_chunk.sv
// Combinational unsigned compare of one CHUNK-wide slice of the operands.
module cmp_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  output logic             eq,
  output logic             lt
);

  assign eq = (a == b);
  assign lt = (a < b);

endmodule

// File: rtl/cmp_iter.sv
// Iterative branch comparator, MSB chunk first, valid/ready on both sides.
// Define CMP_ITER_EARLY_EXIT_EN to finish on the first differing chunk.
module cmp_iter
  import rv32i_types::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  branch_funct3_t   cmpop,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             br_en,
  output logic             bad_op
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0]    LAST = IW'(N - 1);
  localparam logic [WIDTH-1:0] MSB  = {1'b1, {(WIDTH-1){1'b0}}};

`ifdef CMP_ITER_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  cmp_iter_state_t state;
  branch_funct3_t  op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [IW-1:0]    idx;
  logic             eq_sf, lt_sf;

  logic [WIDTH-1:0] a_sh, b_sh;
  logic             c_eq, c_lt, eq_next, lt_next, last;

  assign req_ready = (state == IDLE) && !flush;

  // Shift the current chunk to the top instead of a variable part-select.
  assign a_sh = a_q << (idx * CHUNK);
  assign b_sh = b_q << (idx * CHUNK);

  cmp_chunk #(.CHUNK(CHUNK)) u_chunk (
    .a  (a_sh[WIDTH-1 -: CHUNK]),
    .b  (b_sh[WIDTH-1 -: CHUNK]),
    .eq (c_eq),
    .lt (c_lt)
  );

  // Only the first differing chunk may decide the order.
  assign eq_next = eq_sf & c_eq;
  assign lt_next = eq_sf ? c_lt : lt_sf;
  assign last    = (idx == LAST) || (EARLY_EXIT && eq_sf && !c_eq);

  // NOTE: all state here updates with non-blocking assignments so every
  // register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
      br_en      <= 1'b0;
      bad_op     <= 1'b0;
      idx        <= '0;
      eq_sf      <= 1'b1;
      lt_sf      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= BR_BEQ;
    end else if (flush) begin
      state      <= IDLE;
      resp_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          // Flipping the sign bits turns signed order into unsigned order.
          a_q   <= is_signed_br(cmpop) ? (a ^ MSB) : a;
          b_q   <= is_signed_br(cmpop) ? (b ^ MSB) : b;
          op_q  <= cmpop;
          idx   <= '0;
          eq_sf <= 1'b1;
          lt_sf <= 1'b0;
          state <= BUSY;
        end
        BUSY: begin
          eq_sf <= eq_next;
          lt_sf <= lt_next;
          if (last) begin
            state             <= DONE;
            resp_valid        <= 1'b1;
            {br_en, bad_op}   <= br_resolve(op_q, eq_next, lt_next);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: if (resp_ready) begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_iter.sv
// Directed bench for cmp_iter: vector table plus hold, flush and reset sequences.
// Expected latencies follow CMP_ITER_EARLY_EXIT_EN when it is defined.
module tb_cmp_iter;
  import rv32i_types::*;

  localparam int WIDTH = 32;
  localparam int CHUNK = 8;

`ifdef CMP_ITER_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic           clk;
  logic           rst_n;
  logic           flush;
  logic           req_valid;
  logic           req_ready;
  branch_funct3_t cmpop;
  logic [31:0]    a;
  logic [31:0]    b;
  logic           resp_valid;
  logic           resp_ready;
  logic           br_en;
  logic           bad_op;

  cmp_iter #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .cmpop      (cmpop),
    .a          (a),
    .b          (b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .br_en      (br_en),
    .bad_op     (bad_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    string          name;
    branch_funct3_t op;
    logic [31:0]    opa;
    logic [31:0]    opb;
    logic           br;
    logic           bad;
    int             lat_ee;
    int             lat_full;
  } vec_t;

  vec_t vecs[11];

  // Drive a request on the falling edge; returns at E0 + #1.
  task automatic issue(input branch_funct3_t op, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    cmpop     = op;
    a         = x;
    b         = y;
    req_valid = 1'b1;
    check("req_ready before issue", {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  // Counts edges after E0 until resp_valid; a timeout yields a wrong latency.
  task automatic wait_resp(output int lat);
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_resp();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("resp_valid drops after accept", {31'b0, resp_valid}, 32'd0);
    @(negedge clk);
    resp_ready = 1'b0;
    check("req_ready back in IDLE", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    issue(v.op, v.opa, v.opb);
    wait_resp(lat);
    check({v.name, " latency"}, lat, EE ? v.lat_ee : v.lat_full);
    check({v.name, " br_en"}, {31'b0, br_en}, {31'b0, v.br});
    check({v.name, " bad_op"}, {31'b0, bad_op}, {31'b0, v.bad});
    release_resp();
    check({v.name, " br_en held"}, {31'b0, br_en}, {31'b0, v.br});
  endtask

  initial begin
    int lat;
    int rises;

    vecs[0]  = '{"blt -1<1",        BR_BLT,  32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 1, 4};
    vecs[1]  = '{"bltu max<1",      BR_BLTU, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1, 4};
    vecs[2]  = '{"beq equal",       BR_BEQ,  32'h1234_5678, 32'h1234_5678, 1'b1, 1'b0, 4, 4};
    vecs[3]  = '{"bne equal",       BR_BNE,  32'h1234_5678, 32'h1234_5678, 1'b0, 1'b0, 4, 4};
    vecs[4]  = '{"bne chunk2",      BR_BNE,  32'h0000_0100, 32'h0000_0200, 1'b1, 1'b0, 3, 4};
    vecs[5]  = '{"bgeu chunk2",     BR_BGEU, 32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0, 3, 4};
    vecs[6]  = '{"bge min>=max",    BR_BGE,  32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1, 4};
    vecs[7]  = '{"bltu chunk3",     BR_BLTU, 32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 4, 4};
    vecs[8]  = '{"rsv3 op",         BR_RSV3, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 4, 4};
    vecs[9]  = '{"blt 5<-5",        BR_BLT,  32'h0000_0005, 32'hFFFF_FFFB, 1'b0, 1'b0, 1, 4};
    vecs[10] = '{"beq chunk1",      BR_BEQ,  32'h1234_5678, 32'h1235_5678, 1'b0, 1'b0, 2, 4};

    rst_n      = 1'b0;
    flush      = 1'b0;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    cmpop      = BR_BEQ;
    a          = '0;
    b          = '0;
    #1;
    check("reset resp_valid", {31'b0, resp_valid}, 32'd0);
    check("reset br_en", {31'b0, br_en}, 32'd0);
    check("reset bad_op", {31'b0, bad_op}, 32'd0);
    check("reset req_ready", {31'b0, req_ready}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // req_ready depends combinationally on flush even in IDLE.
    @(negedge clk);
    flush = 1'b1;
    #1;
    check("flush masks req_ready", {31'b0, req_ready}, 32'd0);
    flush = 1'b0;
    #1;
    check("req_ready after flush low", {31'b0, req_ready}, 32'd1);

    for (int i = 0; i < 11; i++) run_vec(vecs[i]);

    // Result held while the consumer stalls; no new request accepted in DONE.
    issue(BR_BGE, 32'h8000_0000, 32'h8000_0000);
    wait_resp(lat);
    check("hold latency", lat, 4);
    @(negedge clk);
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold resp_valid", {31'b0, resp_valid}, 32'd1);
      check("hold br_en", {31'b0, br_en}, 32'd1);
      check("hold req_ready", {31'b0, req_ready}, 32'd0);
    end
    @(negedge clk);
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    check("hold release resp_valid", {31'b0, resp_valid}, 32'd0);
    check("hold release req_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    resp_ready = 1'b0;

    // Flush in the second BUSY cycle aborts without a response.
    issue(BR_BEQ, 32'hCAFE_F00D, 32'hCAFE_F00D);
    @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush returns to IDLE", {31'b0, req_ready}, 32'd1);
    rises = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) rises++;
    end
    check("no response after flush", rises, 0);
    run_vec('{"rsv2 after flush", BR_RSV2, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 4, 4});

    // Asynchronous reset mid-compare aborts and clears the result.
    issue(BR_BEQ, 32'h0000_0000, 32'h0000_0000);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid reset req_ready", {31'b0, req_ready}, 32'd1);
    check("mid reset bad_op", {31'b0, bad_op}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rises = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (resp_valid) rises++;
    end
    check("no response after reset", rises, 0);
    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
